// File: rtl/data_table_wr_arbiter.sv
// Write-port arbiter for the data table RAM: a full-RAM zero-fill engine plus a
// round-robin merge of insert and delete write requests onto one registered port.
module data_table_wr_arbiter #(
  parameter int unsigned A_WIDTH = 10,
  parameter int unsigned D_WIDTH = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,

  input  logic               clear_ram_run_i,
  output logic               clear_ram_done_o,
  output logic               busy_o,

  input  logic               ins_wr_req_i,
  input  logic [A_WIDTH-1:0] ins_wr_addr_i,
  input  logic [D_WIDTH-1:0] ins_wr_data_i,
  output logic               ins_wr_ack_o,

  input  logic               del_wr_req_i,
  input  logic [A_WIDTH-1:0] del_wr_addr_i,
  input  logic [D_WIDTH-1:0] del_wr_data_i,
  output logic               del_wr_ack_o,

  output logic               wr_en_o,
  output logic [A_WIDTH-1:0] wr_addr_o,
  output logic [D_WIDTH-1:0] wr_data_o
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  logic               last_del_q, last_del_d;
  logic               wr_en_q, wr_en_d;
  logic [A_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [D_WIDTH-1:0] wr_data_q, wr_data_d;
  logic               done_q, done_d;

  logic arb_ok;
  logic ins_gnt;
  logic del_gnt;

  // A clear request in the same cycle pre-empts any grant.
  assign arb_ok  = (state_q == StIdle) && !clear_ram_run_i && !rst_i;
  assign ins_gnt = arb_ok && ins_wr_req_i && (!del_wr_req_i || last_del_q);
  assign del_gnt = arb_ok && del_wr_req_i && (!ins_wr_req_i || !last_del_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_del_d = last_del_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clear_ram_run_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (ins_gnt) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = ins_wr_addr_i;
          wr_data_d  = ins_wr_data_i;
          last_del_d = 1'b0;
        end else if (del_gnt) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = del_wr_addr_i;
          wr_data_d  = del_wr_data_i;
          last_del_d = 1'b1;
        end
      end
      StClear: begin
        if (clear_ram_run_i) begin
          // Restart: this cycle issues nothing and the aborted pass never signals done.
          cnt_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = '0;
          if (cnt_q == {A_WIDTH{1'b1}}) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + A_WIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_del_q <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_del_q <= last_del_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  assign busy_o           = (state_q == StClear);
  assign ins_wr_ack_o     = ins_gnt;
  assign del_wr_ack_o     = del_gnt;
  assign wr_en_o          = wr_en_q;
  assign wr_addr_o        = wr_addr_q;
  assign wr_data_o        = wr_data_q;
  assign clear_ram_done_o = done_q;

endmodule

// File: tb/tb_data_table_wr_arbiter.sv
// Bench for data_table_wr_arbiter: directed literal scenarios plus a long random run,
// all checked every cycle against a transaction-level model of the write port.
module tb_data_table_wr_arbiter;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          done, busy;
  logic          ins_req = 1'b0, del_req = 1'b0;
  logic [AW-1:0] ins_addr = '0, del_addr = '0;
  logic [DW-1:0] ins_data = '0, del_data = '0;
  logic          ins_ack, del_ack;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int failures = 0;

  data_table_wr_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clear_ram_run_i (run),
    .clear_ram_done_o(done),
    .busy_o          (busy),
    .ins_wr_req_i    (ins_req),
    .ins_wr_addr_i   (ins_addr),
    .ins_wr_data_i   (ins_data),
    .ins_wr_ack_o    (ins_ack),
    .del_wr_req_i    (del_req),
    .del_wr_addr_i   (del_addr),
    .del_wr_data_i   (del_data),
    .del_wr_ack_o    (del_ack),
    .wr_en_o         (wr_en),
    .wr_addr_o       (wr_addr),
    .wr_data_o       (wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a clear pass is a list of pending addresses; arbitration remembers who won last.
  bit          m_clearing;
  int          m_next;
  bit          m_last_del;
  bit          e_en, e_done;
  int          e_addr, e_data;
  bit          ins_ack_s, del_ack_s;

  always @(negedge clk) begin
    bit g_ins, g_del;
    if (rst) begin
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ins_ack", 32'(ins_ack), 0);
      chk("rst_del_ack", 32'(del_ack), 0);
      m_clearing = 0; m_next = 0; m_last_del = 1;
      e_en = 0; e_done = 0; e_addr = 0; e_data = 0;
      ins_ack_s = 0; del_ack_s = 0;
    end else begin
      g_ins = 0; g_del = 0;
      if (!m_clearing && !run) begin
        if (ins_req && del_req) begin
          if (m_last_del) g_ins = 1; else g_del = 1;
        end else begin
          g_ins = ins_req; g_del = del_req;
        end
      end
      chk("m_busy", 32'(busy), 32'(m_clearing));
      chk("m_ins_ack", 32'(ins_ack), 32'(g_ins));
      chk("m_del_ack", 32'(del_ack), 32'(g_del));
      chk("m_wr_en", 32'(wr_en), 32'(e_en));
      chk("m_wr_addr", 32'(wr_addr), 32'(e_addr));
      chk("m_wr_data", 32'(wr_data), 32'(e_data));
      chk("m_done", 32'(done), 32'(e_done));
      ins_ack_s = ins_ack; del_ack_s = del_ack;
      e_en = 0; e_done = 0;
      if (run) begin
        m_clearing = 1; m_next = 0;
      end else if (m_clearing) begin
        e_en = 1; e_addr = m_next; e_data = 0;
        if (m_next == (1 << AW) - 1) begin
          e_done = 1; m_clearing = 0;
        end else begin
          m_next++;
        end
      end else if (g_ins) begin
        e_en = 1; e_addr = int'(ins_addr); e_data = int'(ins_data); m_last_del = 0;
      end else if (g_del) begin
        e_en = 1; e_addr = int'(del_addr); e_data = int'(del_data); m_last_del = 1;
      end
    end
  end

  initial begin
    logic [DW-1:0] seq [4];
    seq = '{8'h11, 8'h21, 8'h12, 8'h22};
    repeat (2) step();
    rst = 1'b0;
    step();

    // Full clear pass, pulse in cycle 0.
    run = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      chk("clr_busy", 32'(busy), 32'(c >= 1 && c <= 8));
      chk("clr_en", 32'(wr_en), 32'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) begin
        chk("clr_addr", 32'(wr_addr), 32'(c - 2));
        chk("clr_data", 32'(wr_data), 0);
      end
      chk("clr_done", 32'(done), 32'(c == 9));
      step();
      run = 1'b0;
    end

    // Single insert request in idle.
    ins_req = 1'b1; ins_addr = 3'd5; ins_data = 8'hA5;
    @(negedge clk);
    chk("single_ack", 32'(ins_ack), 1);
    step();
    ins_req = 1'b0;
    @(negedge clk);
    chk("single_en", 32'(wr_en), 1);
    chk("single_addr", 32'(wr_addr), 5);
    chk("single_data", 32'(wr_data), 32'hA5);
    step();
    @(negedge clk);
    chk("single_en_off", 32'(wr_en), 0);
    chk("single_addr_hold", 32'(wr_addr), 5);
    step();

    // Contention right after reset: insert wins first, then alternate.
    rst = 1'b1;
    step();
    rst = 1'b0;
    ins_req = 1'b1; del_req = 1'b1; ins_addr = 3'd1; del_addr = 3'd2;
    for (int k = 0; k < 4; k++) begin
      ins_data = 8'h11 + 8'((k + 1) >> 1);
      del_data = 8'h21 + 8'(k >> 1);
      @(negedge clk);
      chk("rr_ins_ack", 32'(ins_ack), 32'(k % 2 == 0));
      chk("rr_del_ack", 32'(del_ack), 32'(k % 2 == 1));
      if (k > 0) chk("rr_data", 32'(wr_data), 32'(seq[k-1]));
      step();
    end
    ins_req = 1'b0; del_req = 1'b0;
    @(negedge clk);
    chk("rr_data_last", 32'(wr_data), 32'(seq[3]));
    step();

    // Insert held through a clear pass.
    run = 1'b1; ins_req = 1'b1; ins_addr = 3'd3; ins_data = 8'h5C;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      chk("blk_ack", 32'(ins_ack), 32'(c == 9));
      if (c == 10) begin
        chk("blk_en", 32'(wr_en), 1);
        chk("blk_addr", 32'(wr_addr), 3);
        chk("blk_data", 32'(wr_data), 32'h5C);
      end
      step();
      run = 1'b0;
      if (c == 9) ins_req = 1'b0;
    end

    // Restart at cycle 4.
    run = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      chk("rs_en", 32'(wr_en), 32'((c >= 2 && c <= 4) || (c >= 6 && c <= 13)));
      if (c >= 2 && c <= 4) chk("rs_addr_a", 32'(wr_addr), 32'(c - 2));
      if (c >= 6 && c <= 13) chk("rs_addr_b", 32'(wr_addr), 32'(c - 6));
      chk("rs_done", 32'(done), 32'(c == 13));
      step();
      run = (c == 3);
    end

    // Reset in cycle 5 of a clear pass, with a pending insert.
    run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      run = 1'b0;
    end
    ins_req = 1'b1; ins_addr = 3'd6; ins_data = 8'h77;
    rst = 1'b1;
    #1;
    chk("mid_rst_en", 32'(wr_en), 0);
    chk("mid_rst_addr", 32'(wr_addr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ack", 32'(ins_ack), 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_busy", 32'(busy), 0);
      step();
      if (ins_ack_s) ins_req = 1'b0;
    end
    ins_req = 1'b0;

    // Random traffic; requesters hold until acked.
    for (int i = 0; i < 4000; i++) begin
      step();
      if (ins_req && ins_ack_s) ins_req = 1'b0;
      if (del_req && del_ack_s) del_req = 1'b0;
      if (!ins_req && $urandom_range(0, 2) == 0) begin
        ins_req = 1'b1; ins_addr = AW'($urandom); ins_data = DW'($urandom);
      end
      if (!del_req && $urandom_range(0, 2) == 0) begin
        del_req = 1'b1; del_addr = AW'($urandom); del_data = DW'($urandom);
      end
      run = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 599) == 0);
    end
    step();
    rst = 1'b0; run = 1'b0; ins_req = 1'b0; del_req = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_table_wr_arbiter.md
DATA_TABLE_WR_ARBITER -- requirements
Module: data_table_wr_arbiter

Interface
REQ-001 The block SHALL have parameter A_WIDTH, default 10, meaning the data RAM address width (2^A_WIDTH entries).
REQ-002 The block SHALL have parameter D_WIDTH, default 64, meaning the data RAM word width.
REQ-003 Port list, one per line:
- clk_i  input  1  single clock; all logic on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- clear_ram_run_i  input  1  one-cycle pulse; starts a full-RAM zero fill.
- clear_ram_done_o  output  1  one-cycle pulse; the last clear write is on the RAM port.
- busy_o  output  1  high while clearing.
- ins_wr_req_i  input  1  insert engine write request.
- ins_wr_addr_i  input  A_WIDTH  insert write address.
- ins_wr_data_i  input  D_WIDTH  insert write data.
- ins_wr_ack_o  output  1  insert request granted this cycle.
- del_wr_req_i  input  1  delete engine write request.
- del_wr_addr_i  input  A_WIDTH  delete write address.
- del_wr_data_i  input  D_WIDTH  delete write data.
- del_wr_ack_o  output  1  delete request granted this cycle.
- wr_en_o  output  1  RAM write-port enable.
- wr_addr_o  output  A_WIDTH  RAM write-port address.
- wr_data_o  output  D_WIDTH  RAM write-port data.

Function
REQ-004 The FSM SHALL have two states: IDLE and CLEAR.
REQ-005 IDLE -> CLEAR SHALL occur on the edge sampling clear_ram_run_i=1; the clear counter SHALL load 0 on the same edge.
REQ-006 In CLEAR, each cycle SHALL issue one write (address = counter, data = 0) and then increment the counter.
REQ-007 When the counter equals all-ones, that cycle SHALL issue the final write, and the FSM SHALL return to IDLE on that edge.
REQ-008 clear_ram_run_i asserted while in CLEAR SHALL restart the counter at 0 and stay in CLEAR; done SHALL NOT pulse for the aborted pass.
REQ-009 busy_o SHALL be combinational: high exactly when state = CLEAR.
REQ-010 Requests:
- A requester SHALL hold req, addr and data stable until it sees ack.
- ack SHALL be combinational from the current-cycle req, state and priority pointer.
- At most one ack SHALL be high per cycle.
REQ-011 No ack SHALL be given in CLEAR, or in an IDLE cycle where clear_ram_run_i=1 (clear wins).
REQ-012 In IDLE with a single requester active, that requester SHALL be acked.
REQ-013 In IDLE with both active, round-robin SHALL apply: grant the requester not granted most recently; the pointer SHALL update only on a grant.
REQ-014 The priority pointer SHALL reset to "delete last", so insert wins the first contention.
REQ-015 RAM outputs SHALL be registered with 1-cycle latency: an issue or grant in cycle N SHALL give wr_en_o=1 with its addr/data in cycle N+1.
REQ-016 In a cycle with no issue and no grant, the next cycle SHALL have wr_en_o=0, and wr_addr_o/wr_data_o SHALL hold their previous values.
REQ-017 clear_ram_done_o SHALL be registered and high in the same cycle that wr_addr_o = all-ones from the clear pass.
REQ-018 Counter wrap SHALL NOT occur: the FSM exits before the increment from all-ones matters.
REQ-019 wr_data_o for clear writes SHALL be all zeros, D_WIDTH bits.

Reset
REQ-020 On rst_i=1, the following SHALL take effect immediately and asynchronously:
- state = IDLE, counter = 0, pointer = "delete last".
- wr_en_o=0, wr_addr_o=0, wr_data_o=0.
- clear_ram_done_o=0, busy_o=0.
- ins_wr_ack_o=0, del_wr_ack_o=0.
REQ-021 Reset during CLEAR SHALL abort the pass with no done pulse; no write SHALL issue until after rst_i deasserts.

Verification (A_WIDTH=3, D_WIDTH=8)
REQ-022 Clear: pulse clear_ram_run_i at cycle 0.
- wr_en_o=1 cycles 2..9, addr 0..7, data 0x00.
- clear_ram_done_o high only in cycle 9.
- busy_o high cycles 1..8.
REQ-023 Single requester: ins req addr=5 data=0xA5 in IDLE cycle 3.
- ins_wr_ack_o=1 in cycle 3.
- Cycle 4: wr_en_o=1, wr_addr_o=5, wr_data_o=0xA5.
- Cycle 5: wr_en_o=0, wr_addr_o=5 held.
REQ-024 Contention: ins and del both request continuously, 4 grants total.
- Ack order from reset: ins, del, ins, del.
- Data order on the RAM port matches the ack order.
REQ-025 Request blocked by clear: ins req held through a clear pass.
- No ack during cycles 0..8 (clear_ram_run_i at cycle 0, CLEAR cycles 1..8).
- Ack in cycle 9; its write appears in cycle 10.
REQ-026 Restart: clear_ram_run_i at cycle 0 and again at cycle 4.
- Addresses 0,1,2 appear in cycles 2..4, then 0..7 in cycles 6..13.
- Single clear_ram_done_o in cycle 13.
REQ-027 Reset mid-clear: rst_i asserted at cycle 5 of a clear pass.
- All outputs 0 immediately.
- No done pulse, state IDLE after release.
